pipe_stage_mem_latch: RTL and testbench

//  Parametrised pipeline register for the EX/MEM boundary. Carries a generic WIDTH-bit payload plus a valid bit.

---
 rtl/pipe_stage_mem_latch.sv | 108 ++++++++++
 tb/tb_pipe_stage_mem_latch.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/pipe_stage_mem_latch.sv
// rtl/pipe_stage_mem_latch.sv - EX/MEM pipeline register owning the data-memory request handshake
module pipe_stage_mem_latch #(
  parameter int WIDTH          = 32,
  parameter int CNT_W          = 8,
  parameter int TIMEOUT        = 200,
  parameter int CLEAR_ON_FLUSH = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             stall_in,
  input  logic             flush_in,
  input  logic             valid_in,
  input  logic             dren_in,
  input  logic             dwen_in,
  input  logic [WIDTH-1:0] data_in,
  input  logic             dhit,
  output logic             valid_out,
  output logic [WIDTH-1:0] data_out,
  output logic             dmemREN,
  output logic             dmemWEN,
  output logic             stall_out,
  output logic [CNT_W-1:0] wait_cnt,
  output logic             timeout
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [31:0] TMO_M1 = (TIMEOUT > 0) ? 32'(TIMEOUT - 1) : 32'd0;

  logic [1:0]       state_q, state_d;
  logic             ren_q, ren_d;
  logic             wen_q, wen_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tmo_q, tmo_d;
  logic             in_req, advance, tmo_hit;

  assign in_req    = (state_q == REQ);
  assign stall_out = in_req & ~dhit;
  assign advance   = ~stall_in & ~stall_out;
  assign dmemREN   = in_req & ren_q;
  assign dmemWEN   = in_req & wen_q;
  assign valid_out = valid_q;
  assign data_out  = data_q;
  assign wait_cnt  = cnt_q;
  assign timeout   = tmo_q;

  assign tmo_hit = (TIMEOUT != 0) && stall_out && (32'(cnt_q) == TMO_M1);

  always_comb begin
    state_d = state_q;
    ren_d   = ren_q;
    wen_d   = wen_q;
    valid_d = valid_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q | tmo_hit;
    if (flush_in) begin
      state_d = IDLE;
      ren_d   = 1'b0;
      wen_d   = 1'b0;
      valid_d = 1'b0;
      cnt_d   = '0;
      if (CLEAR_ON_FLUSH != 0) data_d = '0;
    end else if (advance) begin
      // A served REQ advances on the same edge, so back-to-back memory ops need no bubble.
      data_d  = data_in;
      valid_d = valid_in;
      ren_d   = valid_in & dren_in;
      wen_d   = valid_in & dwen_in;
      state_d = (valid_in & (dren_in | dwen_in)) ? REQ : IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        REQ: begin
          if (dhit) state_d = DONE;
          else if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
        end
        DONE:    state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      ren_q   <= 1'b0;
      wen_q   <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
      cnt_q   <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ren_q   <= ren_d;
      wen_q   <= wen_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_mem_latch.sv
// tb/tb_pipe_stage_mem_latch.sv - directed bench: default instance plus a small-counter, short-timeout, hold-on-flush instance
module tb_pipe_stage_mem_latch;
  logic        CLK = 1'b0;
  logic        RST, stall_in, flush_in, valid_in, dren_in, dwen_in, dhit;
  logic [31:0] data_in;

  logic        a_valid, a_ren, a_wen, a_stall, a_tmo;
  logic [31:0] a_data;
  logic [7:0]  a_cnt;
  logic        b_valid, b_ren, b_wen, b_stall, b_tmo;
  logic [31:0] b_data;
  logic [1:0]  b_cnt;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  pipe_stage_mem_latch u_a (
    .CLK(CLK), .RST(RST), .stall_in(stall_in), .flush_in(flush_in), .valid_in(valid_in),
    .dren_in(dren_in), .dwen_in(dwen_in), .data_in(data_in), .dhit(dhit),
    .valid_out(a_valid), .data_out(a_data), .dmemREN(a_ren), .dmemWEN(a_wen),
    .stall_out(a_stall), .wait_cnt(a_cnt), .timeout(a_tmo)
  );

  pipe_stage_mem_latch #(.WIDTH(32), .CNT_W(2), .TIMEOUT(4), .CLEAR_ON_FLUSH(0)) u_b (
    .CLK(CLK), .RST(RST), .stall_in(stall_in), .flush_in(flush_in), .valid_in(valid_in),
    .dren_in(dren_in), .dwen_in(dwen_in), .data_in(data_in), .dhit(dhit),
    .valid_out(b_valid), .data_out(b_data), .dmemREN(b_ren), .dmemWEN(b_wen),
    .stall_out(b_stall), .wait_cnt(b_cnt), .timeout(b_tmo)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST = 1'b1; stall_in = 1'b0; flush_in = 1'b0; valid_in = 1'b0;
    dren_in = 1'b0; dwen_in = 1'b0; dhit = 1'b0; data_in = 32'h0;
    tick(); tick();
    chk("rst_valid", {31'd0, a_valid}, 32'd0);
    chk("rst_data", a_data, 32'd0);
    chk("rst_ren", {30'd0, a_ren, a_wen}, 32'd0);
    chk("rst_cnt", {24'd0, a_cnt}, 32'd0);
    chk("rst_tmo", {30'd0, a_tmo, b_tmo}, 32'd0);
    RST = 1'b0;

    // invalid entry flagged as load issues nothing
    valid_in = 1'b0; dren_in = 1'b1; data_in = 32'h77;
    tick();
    chk("inv_ren", {30'd0, a_ren, a_stall}, 32'd0);

    // load, dhit after 3 waiting cycles
    valid_in = 1'b1; dren_in = 1'b1; data_in = 32'hDEAD_BEEF;
    tick();
    valid_in = 1'b1; dren_in = 1'b0; dwen_in = 1'b1; data_in = 32'h1234;
    #1;
    chk("ld_data", a_data, 32'hDEAD_BEEF);
    chk("ld_req0", {29'd0, a_valid, a_ren, a_stall}, 32'h7);
    chk("ld_cnt0", {24'd0, a_cnt}, 32'd0);
    tick();
    chk("ld_cnt1", {24'd0, a_cnt}, 32'd1);
    chk("ld_held", {30'd0, a_ren, a_stall}, 32'h3);
    tick();
    chk("ld_cnt2", {24'd0, a_cnt}, 32'd2);
    chk("ld_cnt2_b", {30'd0, b_cnt}, 32'd2);
    dhit = 1'b1;
    #1;
    chk("ld_hit_stall", {31'd0, a_stall}, 32'd0);
    tick();
    chk("st_data", a_data, 32'h1234);
    chk("st_req", {30'd0, a_ren, a_wen}, 32'h1);
    chk("st_cnt", {24'd0, a_cnt}, 32'd0);

    // store served while stalled goes to DONE
    stall_in = 1'b1; dhit = 1'b1;
    tick();
    dhit = 1'b0; valid_in = 1'b1; dren_in = 1'b1; dwen_in = 1'b0; data_in = 32'h5555;
    #1;
    chk("done_wen", {30'd0, a_wen, a_stall}, 32'd0);
    chk("done_data", a_data, 32'h1234);
    tick();
    chk("done_hold", a_data, 32'h1234);
    chk("done_valid", {31'd0, a_valid}, 32'd1);
    stall_in = 1'b0;
    tick();
    chk("rel_data", a_data, 32'h5555);
    chk("rel_ren", {30'd0, a_ren, a_stall}, 32'h3);

    // flush during REQ with stall
    stall_in = 1'b1; flush_in = 1'b1;
    tick();
    flush_in = 1'b0; stall_in = 1'b0; valid_in = 1'b0; dren_in = 1'b0;
    #1;
    chk("fl_a", {29'd0, a_valid, a_ren, a_stall}, 32'd0);
    chk("fl_a_data", a_data, 32'd0);
    chk("fl_b_data", b_data, 32'h5555);
    chk("fl_b_valid", {30'd0, b_valid, b_ren}, 32'd0);
    chk("fl_b_tmo", {31'd0, b_tmo}, 32'd0);

    // timeout (B: TIMEOUT=4) and saturation (B: CNT_W=2)
    valid_in = 1'b1; dren_in = 1'b1; data_in = 32'hA5;
    tick();
    valid_in = 1'b0; dren_in = 1'b0;
    tick(); tick(); tick();
    chk("tmo_before", {30'd0, b_tmo, a_tmo}, 32'd0);
    chk("tmo_cnt3", {30'd0, b_cnt}, 32'd3);
    tick();
    chk("tmo_set", {31'd0, b_tmo}, 32'd1);
    chk("sat_b4", {30'd0, b_cnt}, 32'd3);
    chk("cnt_a4", {24'd0, a_cnt}, 32'd4);
    tick(); tick();
    chk("sat_b6", {30'd0, b_cnt}, 32'd3);
    chk("cnt_a6", {24'd0, a_cnt}, 32'd6);
    chk("a_no_tmo", {31'd0, a_tmo}, 32'd0);
    dhit = 1'b1;
    tick();
    dhit = 1'b0;
    #1;
    chk("tmo_sticky", {31'd0, b_tmo}, 32'd1);
    chk("after_hit", {29'd0, a_valid, a_ren, a_stall}, 32'd0);
    chk("after_hit_cnt", {30'd0, b_cnt}, 32'd0);

    // asynchronous reset mid-REQ
    valid_in = 1'b1; dwen_in = 1'b1; data_in = 32'hCAFE;
    tick();
    valid_in = 1'b0; dwen_in = 1'b0;
    tick();
    chk("pre_rst_wen", {30'd0, a_wen, a_valid}, 32'h3);
    chk("pre_rst_cnt", {24'd0, a_cnt}, 32'd1);
    #2 RST = 1'b1;
    #1;
    chk("arst_req", {28'd0, a_ren, a_wen, b_ren, b_wen}, 32'd0);
    chk("arst_valid", {31'd0, a_valid}, 32'd0);
    chk("arst_cnt", {24'd0, a_cnt}, 32'd0);
    chk("arst_tmo", {31'd0, b_tmo}, 32'd0);
    tick();
    RST = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
